// File: rtl/seg_ascii_pkg.sv
// Shared seven-segment / ASCII constants and TX FSM encoding used by the
// segment-to-UART path and the forward ASCII-to-segment converter.
package seg_ascii_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_READY
    } tx_state_t;

endpackage

// File: rtl/segment_2_uart_if.sv
// Segment-in / UART-TX-out handshake bundle. The slave side is the converter,
// the master side is whatever feeds segments and models the transmitter.
interface segment_2_uart_if #(parameter int BYTE_W = 8);
    logic [BYTE_W-1:0] seg_in;
    logic              seg_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_load_ok;

    modport master (output seg_in, seg_valid, tx_load_ok, input tx_data, tx_load);
    modport slave  (input seg_in, seg_valid, tx_load_ok, output tx_data, tx_load);
endinterface

// File: rtl/segment_2_uart_fifo.sv
// Single-clock byte FIFO with two write ports (second write lands right
// behind the first in the same cycle), one read port and an occupancy count.
module sync_byte_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en0,
    input  logic [W-1:0]             wr_data0,
    input  logic                     wr_en1,
    input  logic [W-1:0]             wr_data1,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;

    assign wr_ptr_nxt = wr_ptr + PTR_W'(1);
    assign rd_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en0) mem[wr_ptr] <= wr_data0;
        if (wr_en1) mem[wr_ptr_nxt] <= wr_data1;
    end

    // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_en0) + PTR_W'(wr_en1);
            rd_ptr <= rd_ptr + PTR_W'(rd_en);
            count  <= count + CNT_W'(wr_en0) + CNT_W'(wr_en1) - CNT_W'(rd_en);
        end
    end
endmodule

// File: rtl/segment_2_uart.sv
// Decodes seven-segment patterns back to ASCII, buffers them and hands them
// one at a time to the UART transmitter's load interface.
module segment_2_uart
    import seg_ascii_pkg::*;
#(
    parameter int BYTE_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DP_EMIT    = 1
) (
    input  logic                          sys_clk,
    input  logic                          rst_n,
    input  logic                          en,
    segment_2_uart_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [7:0] seg_to_ascii(input logic [6:0] s);
        logic [7:0] c;
        c = ASCII_QMARK;
        case (s)
            7'h3F: c = 8'h30;
            7'h06: c = 8'h31;
            7'h5B: c = 8'h32;
            7'h4F: c = 8'h33;
            7'h66: c = 8'h34;
            7'h6D: c = 8'h35;
            7'h7D: c = 8'h36;
            7'h07: c = 8'h37;
            7'h7F: c = 8'h38;
            7'h6F: c = 8'h39;
            7'h77: c = 8'h41;
            7'h7C: c = 8'h62;
            7'h39: c = 8'h43;
            7'h5E: c = 8'h64;
            7'h79: c = 8'h45;
            7'h71: c = 8'h46;
            7'h00: c = ASCII_SPACE;
            7'h40: c = ASCII_DASH;
            default: c = ASCII_QMARK;
        endcase
        return c;
    endfunction

    tx_state_t         state;
    logic [BYTE_W-1:0] tx_data_r;
    logic              tx_load_r;
    logic              strobe;
    logic              dot_req;
    logic [CNT_W-1:0]  need;
    logic [CNT_W-1:0]  free_slots;
    logic              fits;
    logic              wr0;
    logic              wr1;
    logic              pop;
    logic [BYTE_W-1:0] head;

    // The FIFO write is the registered decode stage; a character and its dot
    // are admitted or refused together so the pair is never split.
    assign strobe     = en & bus.seg_valid;
    assign dot_req    = (DP_EMIT != 0) & bus.seg_in[SEG_DP];
    assign need       = dot_req ? CNT_W'(2) : CNT_W'(1);
    assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
    assign fits       = free_slots >= need;
    assign wr0        = strobe & fits;
    assign wr1        = wr0 & dot_req;
    assign pop        = (state == TX_IDLE) && (fifo_count != '0) && bus.tx_load_ok;

    sync_byte_fifo #(.W(BYTE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .wr_en0   (wr0),
        .wr_data0 (BYTE_W'(seg_to_ascii(bus.seg_in[SEG_G:SEG_A]))),
        .wr_en1   (wr1),
        .wr_data1 (BYTE_W'(ASCII_DOT)),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (fifo_count)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else        overflow <= strobe & ~fits;
    end

    // One load per transmitter busy/ready cycle: wait for the UART to drop
    // its ready flag and raise it again before offering the next byte.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            tx_data_r <= '0;
            tx_load_r <= 1'b0;
        end else begin
            tx_load_r <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (pop) begin
                        state     <= TX_LOAD;
                        tx_data_r <= head;
                        tx_load_r <= 1'b1;
                    end
                end
                TX_LOAD:       state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY:  if (!bus.tx_load_ok) state <= TX_WAIT_READY;
                TX_WAIT_READY: if (bus.tx_load_ok)  state <= TX_IDLE;
                default:       state <= TX_IDLE;
            endcase
        end
    end

    assign bus.tx_data = tx_data_r;
    assign bus.tx_load = tx_load_r;
    assign busy        = (fifo_count != '0) || (state != TX_IDLE);
endmodule

// File: tb/tb_segment_2_uart.sv
// Scoreboard bench for segment_2_uart: directed segment patterns push expected
// ASCII bytes; a monitor pops and compares on every tx_load.
module tb_segment_2_uart;
    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       busy;
    logic       auto_ack;
    logic       ok_auto;
    logic       ok_manual;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int load_cnt = 0;
    int last_load_cyc = 0;
    int ovf_cnt = 0;
    logic [7:0] exp_q[$];

    segment_2_uart_if #(.BYTE_W(8)) bus ();

    segment_2_uart #(.BYTE_W(8), .FIFO_DEPTH(8), .DP_EMIT(1)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .en         (en),
        .bus        (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    assign bus.tx_load_ok = auto_ack ? ok_auto : ok_manual;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: every load is matched against the oldest expected byte.
    always @(negedge sys_clk) begin
        logic [7:0] e;
        if (rst_n === 1'b1 && bus.tx_load === 1'b1) begin
            load_cnt = load_cnt + 1;
            last_load_cyc = cyc;
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("[TB] FAIL unexpected_load got=%h want=none", bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.tx_data !== e) begin
                    bad = bad + 1;
                    $display("[TB] FAIL tx_data got=%h want=%h", bus.tx_data, e);
                end
            end
        end
        if (rst_n === 1'b1 && overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
    end

    // Transmitter model: goes busy two cycles after a load, ready three later.
    initial begin
        ok_auto = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (auto_ack && rst_n === 1'b1 && bus.tx_load === 1'b1) begin
                repeat (2) @(negedge sys_clk);
                ok_auto = 1'b0;
                repeat (3) @(negedge sys_clk);
                ok_auto = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] seg);
        bus.seg_in    = seg;
        bus.seg_valid = 1'b1;
        tick(1);
    endtask

    task automatic idleInputs();
        bus.seg_valid = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < bound) begin
            tick(1);
            n++;
        end
        if (n >= bound) begin
            total = total + 1;
            bad = bad + 1;
            $display("[TB] FAIL wait_idle_timeout got=%0d want<%0d", n, bound);
        end
    endtask

    task automatic waitCountAtMost(input int lim, input int bound);
        int n;
        n = 0;
        while (int'(fifo_count) > lim && n < bound) begin
            tick(1);
            n++;
        end
        if (n >= bound) begin
            total = total + 1;
            bad = bad + 1;
            $display("[TB] FAIL wait_drain_timeout got=%0d want<=%0d", fifo_count, lim);
        end
    endtask

    logic [7:0] stream_seg [20] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F,
                                    8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h00, 8'h40, 8'h12, 8'h7F};
    logic [7:0] stream_asc [20] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                    8'h41, 8'h62, 8'h43, 8'h64, 8'h45, 8'h46, 8'h20, 8'h2D, 8'h3F, 8'h38};

    initial begin
        int c0;
        int l0;
        int o0;
        rst_n = 1'b0;
        en = 1'b1;
        auto_ack = 1'b0;
        ok_manual = 1'b1;
        bus.seg_in = 8'h06;
        bus.seg_valid = 1'b0;

        // Reset held while strobing
        tick(1);
        repeat (4) applyStimulus(8'h06);
        checkOutput("rst_tx_data", 32'(bus.tx_data), 0);
        checkOutput("rst_tx_load", 32'(bus.tx_load), 0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        idleInputs();
        rst_n = 1'b1;
        tick(6);
        checkOutput("post_rst_loads", 32'(load_cnt), 0);
        checkOutput("post_rst_count", 32'(fifo_count), 0);

        // Single decode with latency check
        auto_ack = 1'b1;
        exp_q.push_back(8'h32);
        c0 = cyc;
        applyStimulus(8'h5B);
        idleInputs();
        waitIdle(40);
        checkOutput("latency", 32'(last_load_cyc - c0), 2);
        checkOutput("single_count", 32'(fifo_count), 0);
        checkOutput("single_busy", 32'(busy), 0);

        // Enable low ignores strobes
        en = 1'b0;
        l0 = load_cnt;
        applyStimulus(8'h06);
        idleInputs();
        tick(4);
        checkOutput("en_low_count", 32'(fifo_count), 0);
        checkOutput("en_low_loads", 32'(load_cnt - l0), 0);
        en = 1'b1;

        // Decimal point and unknown pattern
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h2E);
        applyStimulus(8'hF9);
        idleInputs();
        waitIdle(60);
        exp_q.push_back(8'h3F);
        l0 = load_cnt;
        applyStimulus(8'h12);
        idleInputs();
        waitIdle(40);
        checkOutput("qmark_loads", 32'(load_cnt - l0), 1);

        // Overflow: fill to 8, ninth dropped
        auto_ack = 1'b0;
        ok_manual = 1'b0;
        o0 = ovf_cnt;
        repeat (8) exp_q.push_back(8'h31);
        repeat (9) applyStimulus(8'h06);
        idleInputs();
        tick(2);
        checkOutput("full_count", 32'(fifo_count), 8);
        checkOutput("ovf_ninth", 32'(ovf_cnt - o0), 1);
        ok_manual = 1'b1;
        tick(2);
        ok_manual = 1'b0;
        tick(3);
        checkOutput("one_free_count", 32'(fifo_count), 7);
        applyStimulus(8'h86);
        idleInputs();
        tick(2);
        checkOutput("dp_drop_count", 32'(fifo_count), 7);
        checkOutput("ovf_dp_pair", 32'(ovf_cnt - o0), 2);
        auto_ack = 1'b1;
        waitIdle(200);
        checkOutput("drain_count", 32'(fifo_count), 0);

        // Wrap and order in bursts of five
        o0 = ovf_cnt;
        for (int b = 0; b < 4; b++) begin
            waitCountAtMost(3, 200);
            for (int k = 0; k < 5; k++) begin
                exp_q.push_back(stream_asc[b*5+k]);
                applyStimulus(stream_seg[b*5+k]);
            end
            idleInputs();
        end
        waitIdle(400);
        checkOutput("stream_no_ovf", 32'(ovf_cnt - o0), 0);
        checkOutput("stream_queue_left", 32'(exp_q.size()), 0);

        // Reset mid-operation in WAIT_BUSY with 5 queued
        auto_ack = 1'b0;
        ok_manual = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(stream_asc[k]);
            applyStimulus(stream_seg[k]);
        end
        idleInputs();
        tick(1);
        ok_manual = 1'b1;
        tick(4);
        checkOutput("mid_count", 32'(fifo_count), 5);
        checkOutput("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick(1);
        exp_q.delete();
        checkOutput("mid_rst_count", 32'(fifo_count), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_tx_load", 32'(bus.tx_load), 0);
        l0 = load_cnt;
        rst_n = 1'b1;
        tick(10);
        checkOutput("mid_after_loads", 32'(load_cnt - l0), 0);
        checkOutput("mid_after_count", 32'(fifo_count), 0);

        checkOutput("final_queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
